dac_serial_rx: RTL
==================

DAC_SERIAL_RX -- requirements
Module: dac_serial_rx

Interface
REQ-001 Parameter FRAME_BITS, default 32, number of bits per frame (MSB first).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth on each serial input (allowed range 2..3).
REQ-003 clk_dac  input  1  single block clock; all state updates on rising edge.
REQ-004 reset_dac  input  1  asynchronous, active-low reset; assertion is immediate, release is synchronous to clk_dac.
REQ-005 syncb  input  1  frame strobe, active-low; a frame is one low period.
REQ-006 sclk  input  1  serial clock; data is sampled on its falling edge.
REQ-007 sdi  input  1  serial data, changed by the transmitter only while sclk is high or at its rising edge.
REQ-008 data_out  output  FRAME_BITS  last good frame, bit FRAME_BITS-1 first received.
REQ-009 prefix/ctrl/addr/value/feature  outputs  4/4/4/16/4  DAC8568 field split of data_out: [31:28], [27:24], [23:20], [19:4], [3:0]; registered with data_out.
REQ-010 valid  output  1  one-cycle pulse, data_out just updated.
REQ-011 frame_err  output  1  one-cycle pulse, frame ended with wrong bit count.
REQ-012 busy  output  1  high while in SHIFT state.

Function
REQ-013 syncb, sclk and sdi SHALL each pass through SYNC_STAGES flops; sclk_d, syncb_d hold previous synchronized values for edge detection.
REQ-014 Each sclk level SHALL be held at least 1 clk_dac cycle; narrower pulses are unsupported and not detected.
REQ-015 States: WAIT_HIGH, IDLE, SHIFT.
REQ-016 WAIT_HIGH: entered from reset; -> IDLE when synchronized syncb = 1.
REQ-017 IDLE: synchronized syncb falling edge -> SHIFT; shift register and bit counter cleared, overflow flag cleared.
REQ-018 SHIFT: on detected sclk falling edge (sclk_s=0, sclk_d=1) shift sdi_s in at LSB, increment bit counter.
REQ-019 Bit counter SHALL be 6 bits and saturate at FRAME_BITS+1; any falling edge after FRAME_BITS bits sets the overflow flag.
REQ-020 SHIFT: synchronized syncb rising edge -> IDLE; if count = FRAME_BITS and no overflow, load data_out and fields and pulse valid; otherwise pulse frame_err, data_out unchanged.
REQ-021 sclk falling edge and syncb rising edge detected in the same cycle: the bit SHALL be shifted in first, then the count checked including it.
REQ-022 valid/frame_err SHALL be registered, asserting exactly SYNC_STAGES+1 clk_dac rising edges after the raw syncb rising edge; never both high.
REQ-023 sclk edges while in IDLE or WAIT_HIGH SHALL be ignored.
REQ-024 A new syncb falling edge in the cycle immediately after valid SHALL start a new frame without loss.

Reset
REQ-025 During reset: data_out and all fields 0, valid 0, frame_err 0, busy 0, state WAIT_HIGH, counter 0.
REQ-026 Synchronizer flops SHALL reset to syncb=1, sclk=0, sdi=0.
REQ-027 Reset asserted mid-frame SHALL abort it without valid or frame_err; a frame whose syncb was already low at release SHALL be ignored until syncb returns high.

Verification
REQ-028 Frame 0x0300_1234 sent MSB first (sclk 1 cycle high/1 low, syncb high after last fall) -> one valid pulse, data_out=0x03001234, ctrl=3, addr=0, value=0x0123, feature=4, frame_err never high.
REQ-029 Frame of 31 bits then syncb high -> frame_err pulse, valid 0, data_out keeps previous value.
REQ-030 Frame of 33 falling edges -> frame_err pulse, data_out unchanged; next correct 32-bit frame 0xFFFF_FFFF -> valid, data_out=0xFFFFFFFF.
REQ-031 syncb low then high with no sclk edges -> frame_err pulse.
REQ-032 reset_dac low after bit 16 of a frame, released while syncb still low, remaining bits sent -> no valid, no frame_err; following full frame 0xA5A5_5A5A -> valid, data_out=0xA5A55A5A.
REQ-033 Back-to-back frames 0x1 and 0x2 with syncb high for 1 cycle between -> two valid pulses, data_out 0x00000001 then 0x00000002.

Source files
------------

// File: rtl/dac_serial_rx.sv
// ----------------------------------------------------------------------------
// dac_serial_rx
//   Receives DAC8568-style serial frames (syncb low framing, data sampled on
//   sclk falling edge, MSB first) and presents the last good frame together
//   with its field split. All inputs are asynchronous to clk_dac and are
//   resynchronised internally.
//
// Parameters
//   FRAME_BITS  - bits per frame (counter is 6 bits, so at most 62)
//   SYNC_STAGES - synchroniser depth for syncb/sclk/sdi (2..3)
//
// Ports
//   clk_dac    in   block clock, all state on rising edge
//   reset_dac  in   active-low reset, immediate assertion, synchronised release
//   syncb      in   frame strobe, active low
//   sclk       in   serial clock, data captured on its falling edge
//   sdi        in   serial data
//   data_out   out  last good frame (bit FRAME_BITS-1 received first)
//   prefix/ctrl/addr/value/feature  out  DAC8568 fields of data_out
//   valid      out  one-cycle pulse, data_out just updated
//   frame_err  out  one-cycle pulse, frame ended with wrong bit count
//   busy       out  high while a frame is being shifted in
// ----------------------------------------------------------------------------
module dac_serial_rx #(
  parameter int unsigned FRAME_BITS  = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk_dac,
  input  logic                  reset_dac,
  input  logic                  syncb,
  input  logic                  sclk,
  input  logic                  sdi,
  output logic [FRAME_BITS-1:0] data_out,
  output logic [3:0]            prefix,
  output logic [3:0]            ctrl,
  output logic [3:0]            addr,
  output logic [15:0]           value,
  output logic [3:0]            feature,
  output logic                  valid,
  output logic                  frame_err,
  output logic                  busy
);

  typedef enum logic [1:0] {
    WAIT_HIGH,
    IDLE,
    SHIFT
  } state_e;

  localparam logic [5:0] CNT_FULL = 6'(FRAME_BITS);
  localparam logic [5:0] CNT_SAT  = 6'(FRAME_BITS + 1);

  // Reset: asserted immediately, released on a clk_dac edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_dac or negedge reset_dac) begin
    if (!reset_dac) rst_sync_q <= '0;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  // Input synchronisers and previous-value flops for edge detection.
  logic [SYNC_STAGES-1:0] syncb_sync_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] sdi_sync_q;
  logic [SYNC_STAGES-1:0] primed_q;
  logic                   syncb_d_q;
  logic                   sclk_d_q;

  always_ff @(posedge clk_dac or negedge rst_n) begin
    if (!rst_n) begin
      syncb_sync_q <= '1;
      sclk_sync_q  <= '0;
      sdi_sync_q   <= '0;
      primed_q     <= '0;
      syncb_d_q    <= 1'b1;
      sclk_d_q     <= 1'b0;
    end else begin
      syncb_sync_q <= {syncb_sync_q[SYNC_STAGES-2:0], syncb};
      sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      sdi_sync_q   <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
      primed_q     <= {primed_q[SYNC_STAGES-2:0], 1'b1};
      syncb_d_q    <= syncb_sync_q[SYNC_STAGES-1];
      sclk_d_q     <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  logic syncb_s, sclk_s, sdi_s, primed;
  logic sclk_fall, syncb_fall, syncb_rise;

  assign syncb_s    = syncb_sync_q[SYNC_STAGES-1];
  assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
  assign sdi_s      = sdi_sync_q[SYNC_STAGES-1];
  // The synchroniser resets to syncb=1; only trust a high level once every
  // stage holds a post-reset sample, otherwise a frame already in progress at
  // reset release would be mistaken for an idle line.
  assign primed     = primed_q[SYNC_STAGES-1];
  assign sclk_fall  = ~sclk_s & sclk_d_q;
  assign syncb_fall = ~syncb_s & syncb_d_q;
  assign syncb_rise = syncb_s & ~syncb_d_q;

  // Shift datapath next values; a falling sclk in the same cycle as the
  // closing syncb edge is folded in before the count is judged.
  state_e                state_q;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [5:0]            cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  frame_ok;
  logic [31:0]           word_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (sclk_fall) begin
      shift_d = {shift_q[FRAME_BITS-2:0], sdi_s};
      if (cnt_q != CNT_SAT) cnt_d = cnt_q + 6'd1;
      if (cnt_q >= CNT_FULL) ovf_d = 1'b1;
    end
  end

  assign frame_ok = (cnt_d == CNT_FULL) && !ovf_d;
  assign word_d   = 32'(shift_d);

  logic [FRAME_BITS-1:0] data_q;
  logic [3:0]            prefix_q, ctrl_q, addr_q, feature_q;
  logic [15:0]           value_q;
  logic                  valid_q, err_q;

  always_ff @(posedge clk_dac or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_HIGH;
      shift_q   <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      data_q    <= '0;
      prefix_q  <= '0;
      ctrl_q    <= '0;
      addr_q    <= '0;
      value_q   <= '0;
      feature_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        WAIT_HIGH: begin
          if (primed && syncb_s) state_q <= IDLE;
        end
        IDLE: begin
          if (syncb_fall) begin
            state_q <= SHIFT;
            shift_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
          end
        end
        SHIFT: begin
          shift_q <= shift_d;
          cnt_q   <= cnt_d;
          ovf_q   <= ovf_d;
          if (syncb_rise) begin
            state_q <= IDLE;
            if (frame_ok) begin
              data_q    <= shift_d;
              prefix_q  <= word_d[31:28];
              ctrl_q    <= word_d[27:24];
              addr_q    <= word_d[23:20];
              value_q   <= word_d[19:4];
              feature_q <= word_d[3:0];
              valid_q   <= 1'b1;
            end else begin
              err_q     <= 1'b1;
            end
          end
        end
        default: state_q <= WAIT_HIGH;
      endcase
    end
  end

  assign data_out  = data_q;
  assign prefix    = prefix_q;
  assign ctrl      = ctrl_q;
  assign addr      = addr_q;
  assign value     = value_q;
  assign feature   = feature_q;
  assign valid     = valid_q;
  assign frame_err = err_q;
  assign busy      = (state_q == SHIFT);

endmodule
